muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide controller and HI/LO register file for the pipeline's EX stage, beside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and sequences a 32-step shift-add multiply or restoring divide. It holds the pipeline via `stall` while busy and exposes HI/LO to MFHI/MFLO forwarding.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  EX holds a muldiv-class instruction this cycle
- `op`  in  5  control code: `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`, `MTHI_CONTROL`, `MTLO_CONTROL`
- `a`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- `b`  in  32  rt operand (divisor / multiplier)
- `flush`  in  1  cancel in-flight operation (exception/redirect)
- `stall`  out  1  hold IF/ID/EX
- `done`  out  1  one-cycle pulse on HI/LO commit of a mult/div
- `hi_o`, `lo_o`  out  32  current HI/LO registers

## Operation
- States: IDLE, CALC, DONE. 5-bit step counter, 64-bit working register `acc`, latched `|a|`, `|b|`, result-sign bits.
- IDLE: `start` with MULT/MULTU/DIV/DIVU and `flush`=0 latches operands and goes to CALC with counter=0. Signed ops latch two's-complement magnitudes. 0x80000000 stays 0x80000000 as unsigned.
- IDLE: `start` with MTHI (MTLO) writes HI (LO) = `a` at the next edge. No stall, no `done`.
- Any other `op` with `start`, or `start` outside IDLE, is ignored.
- CALC multiply: one shift-add step per cycle; 32 steps give a 64-bit unsigned product.
- CALC divide: one restoring step per cycle; 32 steps give an unsigned quotient and remainder.
- Counter 31 → DONE.
- DONE, mult: {HI,LO} = product, negated if signed and a[31]^b[31].
- DONE, div: LO = quotient, negated if signed and a[31]^b[31]; HI = remainder, negated if signed and a[31].
- Divide by zero (b==0, latched at start): LO=32'hFFFFFFFF, HI=a unchanged; no sign fix.
- DONE always → IDLE. `start` is not sampled in DONE (the same instruction is still in EX).
- `flush` in CALC or DONE → IDLE next edge; HI/LO unchanged; no `done`. `flush` in IDLE suppresses any `start`, including MTHI/MTLO.
- `rst` (any state): IDLE, counter=0, acc=0, HI=LO=0, stall=0, done=0.

## Timing
- `stall` = (IDLE & start & mult/div op & ~flush) | CALC. It is combinational and holds EX in the same cycle the op is presented.
- Cycle 0: op accepted, stall=1. Cycles 1–32: CALC, stall=1. Cycle 33: DONE, stall=0, done=1, HI/LO written at the closing edge.
- `hi_o`/`lo_o` show the new values from cycle 34; 33 stalled cycles per mult/div.
- MTHI/MTLO: value visible on `hi_o`/`lo_o` the cycle after `start`.
- `hi_o`/`lo_o` are register outputs. MFHI/MFLO in the instruction immediately after the commit reads via existing pipeline forwarding, not this block.
- Reset values: stall=0, done=0, hi_o=0, lo_o=0.

## Structure
- `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL`, `MTHI_CONTROL`, `MTLO_CONTROL` go in `defines.vh` as 5-bit codes distinct from all existing ALU control codes.
- State encodings are local `localparam`s.
- One sub-module, `muldiv_step`: combinational single-iteration datapath.
  - Inputs: `acc`, divisor/multiplicand, mode.
  - Output: next `acc`.
  - Top level keeps FSM, counter, sign fix-up and HI/LO.

## Test plan
- MULT a=32'hFFFFFFFD (−3), b=5 → stall high exactly 33 cycles, done pulse in cycle 33, HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
- MULTU a=b=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV a=123, b=0 → LO=32'hFFFFFFFF, HI=123, still 33 stall cycles.
- MTHI a=32'hA5A5A5A5 → hi_o updates next cycle, stall never high. Then DIVU with flush in cycle 10 → stall drops cycle 11, no done, HI stays 32'hA5A5A5A5.
- rst asserted asynchronously mid-CALC → stall, done, hi_o, lo_o all 0 immediately. After release, a new MULTU 6*7 gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared control codes, step-mode type and helpers for the iterative multiply/divide unit.
// Control codes sit in the 5'b11xxx range, which the ALU control space does not use.
package muldiv_unit_pkg;

   localparam logic [4:0] MULT_CONTROL  = 5'b11000;
   localparam logic [4:0] MULTU_CONTROL = 5'b11001;
   localparam logic [4:0] DIV_CONTROL   = 5'b11010;
   localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
   localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
   localparam logic [4:0] MTLO_CONTROL  = 5'b11101;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } step_mode_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == MULT_CONTROL) || (op == MULTU_CONTROL) ||
             (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
   endfunction

   function automatic logic is_signed_op(input logic [4:0] op);
      return (op == MULT_CONTROL) || (op == DIV_CONTROL);
   endfunction

   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add multiply or restoring divide on the 64-bit acc.
// Mult: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}.
module muldiv_step
   import muldiv_unit_pkg::*;
(
   input  logic [63:0] acc,
   input  logic [31:0] opnd,
   input  step_mode_t  mode,
   output logic [63:0] acc_nxt
);

   logic [32:0] sum;
   logic [32:0] rem;
   logic [31:0] diff;

   always_comb begin
      sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
      rem  = acc[63:31];
      // Only used when rem >= opnd, so the difference always fits in 32 bits.
      diff = rem[31:0] - opnd;
      acc_nxt = {1'b0, acc[63:1]};
      if (mode == MODE_DIV) begin
         if (rem >= {1'b0, opnd})
            acc_nxt = {diff, acc[30:0], 1'b1};
         else
            acc_nxt = {rem[31:0], acc[30:0], 1'b0};
      end else if (acc[0]) begin
         acc_nxt = {sum, acc[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers; 33 stalled cycles per op.
// Stall is combinational so EX is held in the same cycle the op is presented.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [63:0] acc, acc_nxt;
   logic [31:0] opnd;
   logic [31:0] a_raw;
   step_mode_t  mode;
   logic        neg_q, neg_r, div0;
   logic [31:0] hi, lo;
   logic [31:0] res_hi, res_lo;
   logic [63:0] prod;
   logic        accept;

   muldiv_step u_step (
      .acc     (acc),
      .opnd    (opnd),
      .mode    (mode),
      .acc_nxt (acc_nxt)
   );

   assign accept = start && !flush && is_muldiv(op);

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = CALC;
               stall     = 1'b1;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (flush)
               state_nxt = IDLE;
            else if (cnt == 5'd31)
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
            done      = !flush;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      prod   = neg_q ? -acc : acc;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (mode == MODE_DIV) begin
         if (div0) begin
            res_hi = a_raw;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = neg_r ? -acc[63:32] : acc[63:32];
            res_lo = neg_q ? -acc[31:0]  : acc[31:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         a_raw <= '0;
         mode  <= MODE_MUL;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  logic sgn;
                  logic is_div;
                  sgn    = is_signed_op(op);
                  is_div = (op == DIV_CONTROL) || (op == DIVU_CONTROL);
                  cnt    <= '0;
                  mode   <= is_div ? MODE_DIV : MODE_MUL;
                  neg_q  <= sgn && (a[31] ^ b[31]);
                  neg_r  <= sgn && a[31];
                  div0   <= (b == 32'd0);
                  a_raw  <= a;
                  // Multiplier (mult) or dividend (div) enters the low half of acc.
                  opnd   <= is_div ? mag32(b, sgn) : mag32(a, sgn);
                  acc    <= {32'd0, is_div ? mag32(a, sgn) : mag32(b, sgn)};
               end else if (start && !flush && op == MTHI_CONTROL) begin
                  hi <= a;
               end else if (start && !flush && op == MTLO_CONTROL) begin
                  lo <= a;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 5'd1;
            end
            DONE: begin
               if (!flush) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi_o = hi;
   assign lo_o = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, done pulse, HI/LO results, flush and async reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        stall, done;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .stall (stall),
      .done  (done),
      .hi_o  (hi_o),
      .lo_o  (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one op and keeps it in EX while stalled; optional flush at cycle flush_at.
   task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, output int stalls, output int done_cyc,
                        output int done_cnt);
      stalls = 0; done_cyc = -1; done_cnt = 0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      for (int c = 0; c < 38; c++) begin
         flush = (c == flush_at);
         #1;
         if (stall) stalls++;
         if (done) begin done_cnt++; done_cyc = c; end
         if (!stall || c == flush_at) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0; flush = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [4:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
      int s, dc, dn;
      do_op(o, x, y, -1, s, dc, dn);
      check({tag, "_stalls"}, 64'(s), 64'd33);
      check({tag, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
      check({tag, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
   endtask

   initial begin
      int s, dc, dn;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
      #1;
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_done",  {63'd0, done},  64'd0);
      check("rst_hi",    {32'd0, hi_o},  64'd0);
      check("rst_lo",    {32'd0, lo_o},  64'd0);
      @(negedge clk);
      rst = 1'b0;

      // MULT -3 * 5 with full latency / done-pulse checks
      do_op(MULT_CONTROL, 32'hFFFF_FFFD, 32'd5, -1, s, dc, dn);
      check("mult_stalls",   64'(s),  64'd33);
      check("mult_done_cyc", 64'(dc), 64'd33);
      check("mult_done_cnt", 64'(dn), 64'd1);
      check("mult_hi", {32'd0, hi_o}, 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", {32'd0, lo_o}, 64'h0000_0000_FFFF_FFF1);

      run_check("multu_max", MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_check("divu",      DIVU_CONTROL,  32'd100,       32'd7,        32'd2,        32'd14);
      run_check("div_neg",   DIV_CONTROL,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_check("div_zero",  DIV_CONTROL,   32'd123,       32'd0,        32'd123,      32'hFFFF_FFFF);
      run_check("mult_min",  MULT_CONTROL,  32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000);

      // MTHI: no stall, no done, visible next cycle
      @(negedge clk);
      start = 1'b1; op = MTHI_CONTROL; a = 32'hA5A5_A5A5; b = '0;
      #1;
      check("mthi_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("mthi_done", {63'd0, done}, 64'd0);
      check("mthi_hi", {32'd0, hi_o}, 64'h0000_0000_A5A5_A5A5);

      // DIVU flushed in cycle 10
      do_op(DIVU_CONTROL, 32'd1000, 32'd3, 10, s, dc, dn);
      check("flush_stalls",   64'(s),  64'd11);
      check("flush_done_cnt", 64'(dn), 64'd0);
      check("flush_hi", {32'd0, hi_o}, 64'h0000_0000_A5A5_A5A5);
      check("flush_lo", {32'd0, lo_o}, 64'h0000_0000_0000_0000);

      // Async reset mid-CALC
      @(negedge clk);
      start = 1'b1; op = MULTU_CONTROL; a = 32'd9; b = 32'd9;
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1; start = 1'b0;
      #1;
      check("arst_stall", {63'd0, stall}, 64'd0);
      check("arst_done",  {63'd0, done},  64'd0);
      check("arst_hi",    {32'd0, hi_o},  64'd0);
      check("arst_lo",    {32'd0, lo_o},  64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_check("multu_6x7", MULTU_CONTROL, 32'd6, 32'd7, 32'd0, 32'd42);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
